event_accumulator: RTL



---
 rtl/event_accum_pkg.sv | 54 +++++
 rtl/event_accum_ram.sv | 49 ++++
 rtl/event_accumulator.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_accum_pkg.sv
// ----------------------------------------------------------------------------
// event_accum_pkg
//
// Shared definitions for the event accumulator:
//   - one-hot state encoding for CLEAR, ARM, CAPTURE, FLUSH and READOUT
//   - log2_ceil(): constant function used to size address and count fields
//   - sat_add(): clamping adder used when ACCUM_SATURATE_EN is defined
// ----------------------------------------------------------------------------
package event_accum_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] ST_CLEAR   = 5'b00001;
    localparam logic [STATE_W-1:0] ST_ARM     = 5'b00010;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 5'b00100;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 5'b01000;
    localparam logic [STATE_W-1:0] ST_READOUT = 5'b10000;

    // Smallest n with 2**n >= value (log2_ceil(1) == 0).
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned n;
        n = 0;
        while ((64'd1 << n) < 64'(value)) begin
            n = n + 1;
        end
        return n;
    endfunction

    // Adds inc to acc and clamps the result to a signed width-bit range.
    // An accumulator already sitting on either limit stays there, so a run
    // that saturates reports the limit rather than drifting back inside.
    // Operands are carried at 64 bits so any legal accumulator width fits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] acc,
        input logic signed [63:0] inc,
        input int unsigned        width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] sum;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sum = acc + inc;
        if (acc == hi || acc == lo) begin
            return acc;
        end else if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/event_accum_ram.sv
// ----------------------------------------------------------------------------
// event_accum_ram
//
// Simple dual-port RAM holding the running sums, DATA_W x DEPTH.
// One write port, one read port with a registered 1-cycle read. The read
// register only updates when re_i is high, so the last word read stays on
// rdata_o while the consumer stalls.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read address
//   rdata_o  out  registered read data (valid the cycle after re_i)
// ----------------------------------------------------------------------------
module event_accum_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array and read register carry no reset; a reset on them
    // would stop the tools mapping this onto block RAM. The controller's
    // CLEAR pass writes every location before it is ever read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/event_accumulator.sv
// ----------------------------------------------------------------------------
// event_accumulator
//
// Coherently sums NUM_EVENTS triggered records of RECORD_LEN signed samples,
// subtracting the sample seen on the trigger cycle (baseline) from every
// sample of that event. Running sums live in event_accum_ram. After the last
// event the record is streamed out over valid/ready, each location being
// cleared as it is accepted.
//
// Build option: define ACCUM_SATURATE_EN to clamp sums to the signed ACC_W
// range (sticky at the limit); otherwise sums wrap modulo 2**ACC_W.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   sample_in    in   signed ADC sample, valid every cycle
//   trigger      in   single-cycle event strobe
//   dout         out  signed summed sample
//   dout_valid   out  dout holds a word
//   dout_ready   in   consumer accepts the word
//   dout_last    out  final word of the record
//   busy         out  high in every state except ARM
//   trig_missed  out  one-cycle pulse when a trigger is ignored
//   event_count  out  events summed so far in the current run
// ----------------------------------------------------------------------------
module event_accumulator
    import event_accum_pkg::*;
#(
    parameter int SAMPLE_W   = 8,
    parameter int RECORD_LEN = 128,
    parameter int NUM_EVENTS = 256,
    parameter int ACC_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_W-1:0]     sample_in,
    input  logic                           trigger,
    output logic signed [ACC_W-1:0]        dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic                           dout_last,
    output logic                           busy,
    output logic                           trig_missed,
    output logic [log2_ceil(NUM_EVENTS):0] event_count
);

    localparam int ADDR_W = log2_ceil(RECORD_LEN);
    localparam int EC_W   = log2_ceil(NUM_EVENTS) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RECORD_LEN - 1);

    logic [STATE_W-1:0]        state_q,       state_d;
    logic [ADDR_W-1:0]         addr_q,        addr_d;
    logic [SAMPLE_W-1:0]       baseline_q,    baseline_d;
    logic signed [SAMPLE_W:0]  corr_q,        corr_d;
    logic [ADDR_W-1:0]         waddr_q,       waddr_d;
    logic                      wpend_q,       wpend_d;
    logic                      flush_q,       flush_d;
    logic [EC_W-1:0]           event_count_q, event_count_d;
    logic                      dout_valid_q,  dout_valid_d;
    logic                      dout_last_q,   dout_last_d;
    logic [ADDR_W-1:0]         out_addr_q,    out_addr_d;
    logic                      rd_done_q,     rd_done_d;
    logic                      trig_missed_q, trig_missed_d;

    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_waddr;
    logic [ACC_W-1:0]          ram_wdata;
    logic                      ram_re;
    logic [ADDR_W-1:0]         ram_raddr;
    logic signed [ACC_W-1:0]   ram_rdata;

    logic signed [SAMPLE_W:0]  sample_ext;
    logic signed [SAMPLE_W:0]  baseline_ext;
    logic signed [ACC_W-1:0]   corr_ext;
    logic signed [ACC_W-1:0]   sum;
    logic [EC_W-1:0]           event_count_inc;
    logic                      accept;

    event_accum_ram #(
        .DATA_W (ACC_W),
        .DEPTH  (RECORD_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Baseline correction at SAMPLE_W+1 bits cannot overflow.
    assign sample_ext   = {sample_in[SAMPLE_W-1], sample_in};
    assign baseline_ext = {baseline_q[SAMPLE_W-1], baseline_q};
    assign corr_ext     = ACC_W'(corr_q);

    // ram_rdata is the running sum for waddr_q, read in the previous cycle.
`ifdef ACCUM_SATURATE_EN
    assign sum = ACC_W'(sat_add(64'(ram_rdata), 64'(corr_ext), ACC_W));
`else
    assign sum = ram_rdata + corr_ext;
`endif

    assign event_count_inc = event_count_q + EC_W'(1);
    assign accept          = dout_valid_q && dout_ready;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        baseline_d    = baseline_q;
        corr_d        = corr_q;
        waddr_d       = waddr_q;
        wpend_d       = 1'b0;
        flush_d       = flush_q;
        event_count_d = event_count_q;
        dout_valid_d  = dout_valid_q;
        dout_last_d   = dout_last_q;
        out_addr_d    = out_addr_q;
        rd_done_d     = rd_done_q;
        trig_missed_d = trigger && (state_q != ST_ARM);
        ram_we        = 1'b0;
        ram_waddr     = waddr_q;
        ram_wdata     = sum;
        ram_re        = 1'b0;
        ram_raddr     = addr_q;

        // Second half of the read-modify-write started in CAPTURE.
        if (wpend_q) begin
            ram_we = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = addr_q;
                ram_wdata = '0;
                addr_d    = addr_q + ADDR_W'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (trigger) begin
                    baseline_d = sample_in;
                    addr_d     = '0;
                    state_d    = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                ram_re  = 1'b1;
                corr_d  = sample_ext - baseline_ext;
                waddr_d = addr_q;
                wpend_d = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                if (addr_q == LAST_ADDR) begin
                    flush_d = 1'b0;
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    event_count_d = event_count_inc;
                    if (event_count_inc == EC_W'(NUM_EVENTS)) begin
                        addr_d       = '0;
                        rd_done_d    = 1'b0;
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        state_d      = ST_READOUT;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end

            ST_READOUT: begin
                // Clear each location as its word is taken.
                if (accept) begin
                    ram_we    = 1'b1;
                    ram_waddr = out_addr_q;
                    ram_wdata = '0;
                end
                // Fetch the next word whenever the output slot is empty or
                // is being emptied this cycle; while stalled the RAM read
                // register is left alone so dout holds.
                if (!dout_valid_q || dout_ready) begin
                    if (!rd_done_q) begin
                        ram_re       = 1'b1;
                        out_addr_d   = addr_q;
                        dout_valid_d = 1'b1;
                        dout_last_d  = (addr_q == LAST_ADDR);
                        rd_done_d    = (addr_q == LAST_ADDR);
                        addr_d       = addr_q + ADDR_W'(1);
                    end else begin
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                    end
                end
                if (accept && dout_last_q) begin
                    event_count_d = '0;
                    state_d       = ST_ARM;
                end
            end

            default: begin
                addr_d  = '0;
                state_d = ST_CLEAR;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            addr_q        <= '0;
            baseline_q    <= '0;
            corr_q        <= '0;
            waddr_q       <= '0;
            wpend_q       <= 1'b0;
            flush_q       <= 1'b0;
            event_count_q <= '0;
            dout_valid_q  <= 1'b0;
            dout_last_q   <= 1'b0;
            out_addr_q    <= '0;
            rd_done_q     <= 1'b0;
            trig_missed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            baseline_q    <= baseline_d;
            corr_q        <= corr_d;
            waddr_q       <= waddr_d;
            wpend_q       <= wpend_d;
            flush_q       <= flush_d;
            event_count_q <= event_count_d;
            dout_valid_q  <= dout_valid_d;
            dout_last_q   <= dout_last_d;
            out_addr_q    <= out_addr_d;
            rd_done_q     <= rd_done_d;
            trig_missed_q <= trig_missed_d;
        end
    end

    assign dout        = ram_rdata;
    assign dout_valid  = dout_valid_q;
    assign dout_last   = dout_last_q;
    assign busy        = (state_q != ST_ARM);
    assign trig_missed = trig_missed_q;
    assign event_count = event_count_q;

endmodule
